// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Fully synchronous parametrised up/down counter with programmable modulus,
//   wrap or saturate at the range ends, parallel load with clamp, count
//   enable through a prescaler, terminal-count flag and wrap/saturate pulse.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE 0 = wrap at the range ends, 1 = hold at the range ends
//   PRESCALE one count step every PRESCALE enabled cycles (>= 1)
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   en       count enable (advances the prescaler)
//   control  direction: 1 = up, 0 = down
//   load     synchronous parallel load strobe (wins over a step)
//   load_val value loaded on load, clamped to MODULUS-1
//   q        registered count
//   tc       terminal count for the current direction (combinational)
//   evt      one-cycle registered pulse after a wrap or saturated step
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             control,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  // Parameter legality is caught at elaboration; the logic does not guard it.
  if (WIDTH < 1 || WIDTH > 62 || MODULUS < 2 ||
      longint'(MODULUS) > (longint'(1) << WIDTH) ||
      PRESCALE < 1 || (SATURATE != 0 && SATURATE != 1)) begin : g_bad_param
    $error("updown_counter_param: illegal parameters W=%0d M=%0d S=%0d P=%0d",
           WIDTH, MODULUS, SATURATE, PRESCALE);
  end

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  // Range limits kept one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MAXV     = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] MODV     = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [PW-1:0]    pre;
  logic             step;
  logic             at_top, at_bot;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] q_nxt;
  logic             evt_nxt;

  assign at_top = ({1'b0, q} == MAXV);
  assign at_bot = (q == '0);
  assign step   = en && (pre == PRE_LAST);
  assign tc     = control ? at_top : at_bot;

  // Out-of-range load values are clamped to the top of the range.
  assign load_q = ({1'b0, load_val} < MODV) ? load_val : MAXV[WIDTH-1:0];

  // Next count for a step. q is always below MODULUS, so the WIDTH-bit
  // increment/decrement cannot overflow once the end cases are split off.
  always_comb begin
    q_nxt   = q;
    evt_nxt = 1'b0;
    if (control) begin
      if (at_top) begin
        evt_nxt = 1'b1;
        if (SATURATE == 0) q_nxt = '0;
      end else begin
        q_nxt = q + ONE;
      end
    end else begin
      if (at_bot) begin
        evt_nxt = 1'b1;
        if (SATURATE == 0) q_nxt = MAXV[WIDTH-1:0];
      end else begin
        q_nxt = q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      pre <= '0;
      evt <= 1'b0;
    end else if (load) begin
      q   <= load_q;
      pre <= '0;
      evt <= 1'b0;
    end else if (step) begin
      q   <= q_nxt;
      pre <= '0;
      evt <= evt_nxt;
    end else begin
      // Enabled cycles without a step advance the prescaler phase only.
      if (en) pre <= pre + PW'(1);
      evt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param. Three instances share clk/rst:
//   d0: W=4 M=10 wrap P=1, d1: W=4 M=16 saturate P=1, d2: W=4 M=10 wrap P=3.
// Every cycle a behavioural model predicts q/evt/tc for all three, pushes the
// predictions to a scoreboard queue and they are popped after the edge.
module tb_updown_counter_param;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      en, control, load, tc, evt;
  logic [2:0][3:0] load_val, q;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en[0]), .control(control[0]), .load(load[0]),
    .load_val(load_val[0]), .q(q[0]), .tc(tc[0]), .evt(evt[0]));

  updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en[1]), .control(control[1]), .load(load[1]),
    .load_val(load_val[1]), .q(q[1]), .tc(tc[1]), .evt(evt[1]));

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst(rst), .en(en[2]), .control(control[2]), .load(load[2]),
    .load_val(load_val[2]), .q(q[2]), .tc(tc[2]), .evt(evt[2]));

  typedef struct {
    int q;
    int evt;
    int tc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   mq[3], mpre[3], mevt[3];

  function automatic int mod_of(int d);
    return (d == 1) ? 16 : 10;
  endfunction
  function automatic int sat_of(int d);
    return (d == 1) ? 1 : 0;
  endfunction
  function automatic int pre_of(int d);
    return (d == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_tc(int d);
    if (control[d]) return (mq[d] == mod_of(d) - 1) ? 1 : 0;
    return (mq[d] == 0) ? 1 : 0;
  endfunction

  // Advance the model by one edge from the currently driven inputs.
  task automatic model_edge(input int d);
    int m;
    m = mod_of(d);
    if (load[d]) begin
      mq[d]   = (int'(load_val[d]) >= m) ? m - 1 : int'(load_val[d]);
      mpre[d] = 0;
      mevt[d] = 0;
    end else if (en[d] && mpre[d] == pre_of(d) - 1) begin
      mpre[d] = 0;
      mevt[d] = 0;
      if (control[d]) begin
        if (mq[d] == m - 1) begin
          mevt[d] = 1;
          if (sat_of(d) == 0) mq[d] = 0;
        end else mq[d] = mq[d] + 1;
      end else begin
        if (mq[d] == 0) begin
          mevt[d] = 1;
          if (sat_of(d) == 0) mq[d] = m - 1;
        end else mq[d] = mq[d] - 1;
      end
    end else begin
      if (en[d]) mpre[d] = mpre[d] + 1;
      mevt[d] = 0;
    end
  endtask

  task automatic cyc();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      model_edge(d);
      e.q = mq[d]; e.evt = mevt[d]; e.tc = exp_tc(d);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      e = sb.pop_front();
      chk($sformatf("d%0d q", d),   int'(q[d]),   e.q);
      chk($sformatf("d%0d evt", d), int'(evt[d]), e.evt);
      chk($sformatf("d%0d tc", d),  int'(tc[d]),  e.tc);
    end
  endtask

  // Drive one instance for one cycle; the others sit idle.
  task automatic run(input int d, input bit e, input bit c, input bit l, input int lv);
    en   = '0;
    load = '0;
    en[d]       = e;
    control[d]  = c;
    load[d]     = l;
    load_val[d] = 4'(lv);
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    en = 3'b111; control = 3'b111; load = '0; load_val = '0;
    for (int d = 0; d < 3; d++) begin mq[d] = 0; mpre[d] = 0; mevt[d] = 0; end
    #12;
    // Held in reset across an enabled edge.
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d q", d),   int'(q[d]),   0);
      chk($sformatf("reset d%0d evt", d), int'(evt[d]), 0);
    end
    rst = 1'b1;

    // Up count with wrap.
    for (int i = 1; i <= 12; i++) begin
      run(0, 1, 1, 0, 0);
      chk("upwrap q", int'(q[0]), i % 10);
      chk("upwrap evt", int'(evt[0]), (i == 10) ? 1 : 0);
      chk("upwrap tc", int'(tc[0]), (i % 10 == 9) ? 1 : 0);
    end

    // Down from 2, tc follows control combinationally.
    run(0, 1, 0, 0, 0);
    run(0, 1, 0, 0, 0);
    chk("down q0", int'(q[0]), 0);
    chk("down tc at 0", int'(tc[0]), 1);
    control[0] = 1'b1;
    #1;
    chk("dir switch tc", int'(tc[0]), 0);
    control[0] = 1'b0;
    #1;
    run(0, 1, 0, 0, 0);
    chk("downwrap q", int'(q[0]), 9);
    chk("downwrap evt", int'(evt[0]), 1);
    run(0, 1, 0, 0, 0);
    chk("down q8", int'(q[0]), 8);
    run(0, 1, 1, 0, 0);
    chk("up after switch", int'(q[0]), 9);

    // Load beats a coincident wrapping step, and clamps.
    run(0, 1, 1, 1, 12);
    chk("load clamp q", int'(q[0]), 9);
    chk("load clamp evt", int'(evt[0]), 0);
    run(0, 0, 1, 1, 3);
    chk("load 3", int'(q[0]), 3);

    // Saturation.
    run(1, 0, 1, 1, 14);
    for (int i = 0; i < 4; i++) begin
      run(1, 1, 1, 0, 0);
      chk("sat up q", int'(q[1]), 15);
      chk("sat up evt", int'(evt[1]), (i == 0) ? 0 : 1);
    end
    run(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      run(1, 1, 0, 0, 0);
      chk("sat dn q", int'(q[1]), 0);
      chk("sat dn evt", int'(evt[1]), (i == 0) ? 0 : 1);
    end

    // Prescaler: step every 3rd enabled cycle, phase held while en=0.
    for (int i = 0; i < 4; i++) run(2, 1, 1, 0, 0);
    chk("pre q after 4", int'(q[2]), 1);
    for (int i = 0; i < 5; i++) run(2, 0, 1, 0, 0);
    chk("pre hold q", int'(q[2]), 1);
    run(2, 1, 1, 0, 0);
    chk("pre resume 1", int'(q[2]), 1);
    run(2, 1, 1, 0, 0);
    chk("pre resume 2", int'(q[2]), 2);
    run(2, 1, 1, 0, 0);

    // Bring d0 to a wrap pulse, then reset between edges.
    for (int i = 0; i < 4; i++) run(0, 1, 0, 0, 0);
    chk("pre-reset evt", int'(evt[0]), 1);
    en = '0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async q0", int'(q[0]), 0);
    chk("async evt0", int'(evt[0]), 0);
    chk("async q1", int'(q[1]), 0);
    chk("async q2", int'(q[2]), 0);
    for (int d = 0; d < 3; d++) begin mq[d] = 0; mpre[d] = 0; mevt[d] = 0; end
    @(negedge clk);
    rst = 1'b1;
    // Full prescale period after release.
    run(2, 1, 1, 0, 0);
    chk("post-reset p1", int'(q[2]), 0);
    run(2, 1, 1, 0, 0);
    chk("post-reset p2", int'(q[2]), 0);
    run(2, 1, 1, 0, 0);
    chk("post-reset p3", int'(q[2]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
